// File: rtl/uart_rx_8n1.sv
// 8N1 serial receiver: pin synchroniser, start-bit detect, mid-bit sampling.
// Emits one-cycle rx_stop on a good frame and frame_err on a bad stop bit.
module uart_rx_8n1 #(
   parameter int CLK_FREQ = 50000000,
   parameter int BAUD     = 9600
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx_pin,
   input  logic       rx_en,
   output logic [7:0] rx_data,
   output logic       rx_stop,
   output logic       frame_err,
   output logic       busy
);

   localparam int BAUD_DIV = CLK_FREQ / BAUD;
   localparam int HALF_DIV = BAUD_DIV / 2;
   localparam int CW       = $clog2(BAUD_DIV);

   localparam logic [CW-1:0] CNT_FULL = CW'(BAUD_DIV - 1);
   localparam logic [CW-1:0] CNT_HALF = CW'(HALF_DIV - 1);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] START = 2'd1;
   localparam logic [1:0] DATA  = 2'd2;
   localparam logic [1:0] STOP  = 2'd3;

   logic          s1_q, s2_q, s3_q;
   logic [1:0]    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    shift_q, shift_d;
   logic [7:0]    data_q, data_d;
   logic          stop_q, stop_d;
   logic          ferr_q, ferr_d;
   logic          busy_q, busy_d;
   logic          fall;

   assign fall = s3_q & ~s2_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + 1'b1;
      bit_d   = bit_q;
      shift_d = shift_q;
      data_d  = data_q;
      stop_d  = 1'b0;
      ferr_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (fall && rx_en) state_d = START;
         end
         START: begin
            if (cnt_q == CNT_HALF) begin
               if (!s2_q) begin
                  state_d = DATA;
                  bit_d   = 3'd0;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         DATA: begin
            if (cnt_q == CNT_FULL) begin
               shift_d = {s2_q, shift_q[7:1]};
               bit_d   = bit_q + 1'b1;
               cnt_d   = '0;
               if (bit_q == 3'd7) state_d = STOP;
            end
         end
         STOP: begin
            // Back to IDLE at the stop mid-point so a tight next start is seen
            if (cnt_q == CNT_FULL) begin
               state_d = IDLE;
               if (s2_q) begin
                  data_d = shift_q;
                  stop_d = 1'b1;
               end else begin
                  ferr_d = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      if (state_d != state_q) cnt_d = '0;
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         s1_q    <= 1'b1;
         s2_q    <= 1'b1;
         s3_q    <= 1'b1;
         state_q <= IDLE;
         cnt_q   <= '0;
         bit_q   <= 3'd0;
         shift_q <= 8'h00;
         data_q  <= 8'h00;
         stop_q  <= 1'b0;
         ferr_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         s1_q    <= rx_pin;
         s2_q    <= s1_q;
         s3_q    <= s2_q;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         data_q  <= data_d;
         stop_q  <= stop_d;
         ferr_q  <= ferr_d;
         busy_q  <= busy_d;
      end
   end

   assign rx_data   = data_q;
   assign rx_stop   = stop_q;
   assign frame_err = ferr_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_uart_rx_8n1.sv
// Bench for uart_rx_8n1: table of frames plus hand-built corner sequences,
// with a scoreboard of expected strobes matched against observed ones.
module tb_uart_rx_8n1;

   localparam int BD = 16;

   logic       clk = 1'b0;
   logic       rst;
   logic       rx_pin;
   logic       rx_en;
   logic [7:0] rx_data;
   logic       rx_stop;
   logic       frame_err;
   logic       busy;

   uart_rx_8n1 #(.CLK_FREQ(160), .BAUD(10)) dut (
      .clk       (clk),
      .rst       (rst),
      .rx_pin    (rx_pin),
      .rx_en     (rx_en),
      .rx_data   (rx_data),
      .rx_stop   (rx_stop),
      .frame_err (frame_err),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       ferr;
      logic [7:0] data;
      int         cyc;
   } ev_t;

   typedef struct {
      logic [7:0] d;
      bit         sb;
      bit         en;
   } vec_t;

   ev_t  obs_q[$];
   ev_t  exp_q[$];
   int   cyc = 0;
   bit   both_hi = 1'b0;
   int   n_chk = 0;
   int   n_fail = 0;
   logic [7:0] last_good = 8'h00;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (rst === 1'b1) begin
         if (rx_stop && frame_err) both_hi = 1'b1;
         if (rx_stop || frame_err)
            obs_q.push_back('{frame_err, rx_data, cyc});
      end
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic chk_rng(input string nm, input int act,
                          input int lo, input int hi);
      n_chk++;
      if (act < lo || act > hi) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d..%0d", nm, act, lo, hi);
      end
   endtask

   task automatic push_good(input logic [7:0] d);
      exp_q.push_back('{1'b0, d, 0});
      last_good = d;
   endtask

   task automatic push_err();
      exp_q.push_back('{1'b1, last_good, 0});
   endtask

   task automatic score(input string nm);
      ev_t o, e;
      chk({nm, " events"}, obs_q.size(), exp_q.size());
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         o = obs_q.pop_front();
         e = exp_q.pop_front();
         chk({nm, " kind"}, {31'd0, o.ferr}, {31'd0, e.ferr});
         chk({nm, " data"}, {24'd0, o.data}, {24'd0, e.data});
      end
      obs_q.delete();
      exp_q.delete();
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_bit(input logic b);
      rx_pin = b;
      idle(BD);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic sb,
                             input int drop_at);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) begin
         if (i == drop_at) rx_en = 1'b0;
         send_bit(d[i]);
      end
      send_bit(sb);
   endtask

   vec_t tab[6];
   int   fall_c;

   initial begin
      tab[0] = '{8'h5A, 1'b1, 1'b1};
      tab[1] = '{8'h00, 1'b1, 1'b1};
      tab[2] = '{8'hFF, 1'b1, 1'b1};
      tab[3] = '{8'h12, 1'b1, 1'b0};
      tab[4] = '{8'h81, 1'b0, 1'b1};
      tab[5] = '{8'h01, 1'b1, 1'b1};

      rst    = 1'b0;
      rx_pin = 1'b1;
      rx_en  = 1'b1;
      @(negedge clk);
      chk("rst rx_data", {24'd0, rx_data}, 32'h00);
      chk("rst rx_stop", {31'd0, rx_stop}, 32'd0);
      chk("rst frame_err", {31'd0, frame_err}, 32'd0);
      chk("rst busy", {31'd0, busy}, 32'd0);
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("post rst rx_data", {24'd0, rx_data}, 32'h00);
      chk("post rst rx_stop", {31'd0, rx_stop}, 32'd0);
      chk("post rst frame_err", {31'd0, frame_err}, 32'd0);
      chk("post rst busy", {31'd0, busy}, 32'd0);
      @(posedge clk);
      #1;
      idle(5);

      // single frame with latency
      push_good(8'hA5);
      fall_c = cyc;
      send_frame(8'hA5, 1'b1, -1);
      idle(20);
      if (obs_q.size() > 0)
         chk_rng("a5 latency", obs_q[0].cyc - fall_c, 154, 156);
      score("a5");
      chk("a5 rx_data", {24'd0, rx_data}, 32'hA5);

      // table of frames
      for (int i = 0; i < 6; i++) begin
         rx_en = tab[i].en;
         if (tab[i].en) begin
            if (tab[i].sb) push_good(tab[i].d);
            else push_err();
         end
         send_frame(tab[i].d, tab[i].sb, -1);
         rx_pin = 1'b1;
         rx_en  = 1'b1;
         idle(20);
         score($sformatf("vec%0d", i));
         chk($sformatf("vec%0d rx_data", i), {24'd0, rx_data},
             {24'd0, last_good});
         chk($sformatf("vec%0d busy", i), {31'd0, busy}, 32'd0);
      end

      // back-to-back
      push_good(8'h3C);
      push_good(8'hFF);
      send_frame(8'h3C, 1'b1, -1);
      send_frame(8'hFF, 1'b1, -1);
      idle(20);
      if (obs_q.size() >= 2)
         chk_rng("b2b gap", obs_q[1].cyc - obs_q[0].cyc, 159, 161);
      score("b2b");

      // short glitch
      rx_pin = 1'b0;
      idle(4);
      chk("glitch busy", {31'd0, busy}, 32'd1);
      rx_pin = 1'b1;
      idle(30);
      chk("glitch idle", {31'd0, busy}, 32'd0);
      score("glitch");

      // rx_en drops mid-frame
      push_good(8'h55);
      send_frame(8'h55, 1'b1, 3);
      idle(20);
      score("en drop");
      rx_en = 1'b1;
      idle(5);

      // framing error then break
      push_err();
      send_frame(8'h81, 1'b0, -1);
      idle(40);
      chk("break busy", {31'd0, busy}, 32'd0);
      chk("break rx_data", {24'd0, rx_data}, {24'd0, last_good});
      score("break");
      rx_pin = 1'b1;
      idle(20);
      push_good(8'h07);
      send_frame(8'h07, 1'b1, -1);
      idle(20);
      score("after break");
      chk("after break rx_data", {24'd0, rx_data}, 32'h07);

      // reset mid-frame during bit 4 of F0
      send_bit(1'b0);
      for (int i = 0; i < 4; i++) send_bit(1'b0);
      rx_pin = 1'b1;
      idle(8);
      rst = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("mid rst busy", {31'd0, busy}, 32'd0);
      chk("mid rst rx_data", {24'd0, rx_data}, 32'h00);
      chk("mid rst rx_stop", {31'd0, rx_stop}, 32'd0);
      chk("mid rst frame_err", {31'd0, frame_err}, 32'd0);
      last_good = 8'h00;
      @(posedge clk);
      #1 rst = 1'b1;
      idle(30);
      score("mid rst");
      push_good(8'h42);
      send_frame(8'h42, 1'b1, -1);
      idle(20);
      score("after rst");
      chk("after rst rx_data", {24'd0, rx_data}, 32'h42);

      chk("stop and err together", {31'd0, both_hi}, 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_rx_8n1.md
Name: uart_rx_8n1

Overview:
- Serial receive front end for the beeper-music UART path; sits directly upstream of the receive-control stage that latches the received note code.
- Synchronises the raw RX pin and detects start bits. Samples 8N1 frames at mid-bit.
- Presents each received byte on rx_data with a one-cycle rx_stop strobe. rx_en from the downstream control stage gates when new frames may start.

Parameters:
- CLK_FREQ, 50000000, system clock frequency in Hz.
- BAUD, 9600, line rate in bit/s. Internal BAUD_DIV = CLK_FREQ/BAUD (integer divide); HALF_DIV = BAUD_DIV/2. BAUD_DIV must be at least 4.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous reset, active-low, sampled on rising edge of clk.
- rx_pin  input  1  asynchronous serial line, idles high.
- rx_en  input  1  high = receiver may accept a new start bit; low = start detection suppressed.
- rx_data  output  8  last correctly framed byte, LSB received first.
- rx_stop  output  1  one-cycle pulse: rx_data was just updated.
- frame_err  output  1  one-cycle pulse: stop bit sampled low; byte discarded.
- busy  output  1  high while state is not IDLE.

Behaviour:
- Reset: when rst=0 at a clock edge, the next state is IDLE.
  - rx_data=8'h00, rx_stop=0, frame_err=0, busy=0.
  - Baud counter=0, bit index=0, shift register=0.
  - Both synchroniser flops=1.
  - Reset mid-frame abandons the frame silently; no strobe is issued.
- Synchroniser: rx_pin passes through 2 flops (s1, s2). A third flop s3 holds the previous s2. Falling edge = s3=1 and s2=0.
- The baud counter cnt runs 0..BAUD_DIV-1 and is cleared on every state change.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: on a falling edge with rx_en=1 -> START, cnt=0.
    - A falling edge while rx_en=0 is ignored and is not remembered.
  - START: when cnt==HALF_DIV-1, sample s2.
    - s2=0 -> DATA, cnt=0, bit index=0.
    - s2=1 -> IDLE (glitch reject); no strobe.
  - DATA: when cnt==BAUD_DIV-1, the sample point is one full bit after the start mid-point.
    - Shift s2 into the shift register MSB, shifting right, so bit 0 ends LSB. Then cnt=0 and bit index+1.
    - After the 8th sample -> STOP.
  - STOP: when cnt==BAUD_DIV-1, sample s2, then -> IDLE.
    - s2=1: rx_data<=shift register and rx_stop=1 for exactly the following cycle.
    - s2=0: frame_err=1 for exactly the following cycle; rx_data holds its old value.
- Re-arm: return to IDLE at the stop-bit mid-point, so a start bit following immediately is caught.
  - After a frame error with the line held low (break), no new frame starts until the line has gone high and then falls again.
- rx_en falling mid-frame: the frame in progress completes and strobes normally. rx_en affects only the IDLE->START decision.
- Latency: rx_stop is asserted 2 + 1 + HALF_DIV + 9*BAUD_DIV cycles (±1) after the rx_pin falling edge, counted from the first clock at which rx_pin is low.
- rx_stop and frame_err are never high together. Neither is high for more than 1 cycle per frame.
- busy = (state != IDLE), registered with the state.

Test Plan:
- Bench parameters: CLK_FREQ=160, BAUD=10 (BAUD_DIV=16, HALF_DIV=8); rst low for 3 cycles, then high.
- Reset: check rx_data=8'h00, rx_stop=0, frame_err=0, busy=0 while rst=0 and 1 cycle after release with rx_pin=1.
- Single frame: rx_en=1, send 8'hA5 (start 0, bits 1,0,1,0,0,1,0,1, stop 1), 16 cycles per bit -> rx_data=8'hA5 with exactly one rx_stop pulse at 155±1 cycles after the falling edge; frame_err stays 0.
- Back-to-back: send 8'h3C then immediately 8'hFF with no idle gap -> two rx_stop pulses 160±1 cycles apart; rx_data reads 8'h3C after the first pulse and 8'hFF after the second.
- Glitch and gating:
  - Drive rx_pin low for 4 cycles in IDLE -> busy returns to 0 and no strobe occurs.
  - With rx_en=0, send 8'h12 -> no strobe and rx_data unchanged.
  - Drop rx_en mid-frame of 8'h55 -> rx_data=8'h55 is still strobed.
- Framing error: send 8'h81 with stop bit 0, then hold the line low for 40 cycles -> one frame_err pulse, rx_stop=0, rx_data keeps its previous value, busy=0. Raise the line, send 8'h07 -> rx_data=8'h07.
- Reset mid-frame: assert rst=0 during bit 4 of 8'hF0 -> next cycle state is IDLE, all outputs at reset values, no strobe. Release and send 8'h42 -> rx_data=8'h42.
